// File: rtl/axi_csr_bridge.sv
// AXI4-Lite subordinate that turns single AXI reads/writes into transactions
// on the NI CSR request/response interface, one transaction at a time.
// Optional feature macro: AXI_CSR_BRIDGE_RMW_EN -- partial-strobe writes are
// carried out as a CSR read-modify-write instead of being refused with SLVERR.
module axi_csr_bridge #(
  parameter int                   AddrWidth  = 32,
  parameter int                   DataWidth  = 32,
  parameter logic [AddrWidth-1:0] BaseAddr   = 'h0000_1000,
  parameter logic [AddrWidth-1:0] WindowSize = 'h100
) (
  input  logic                 clk_axi,
  input  logic                 arst_axi,
  input  logic [AddrWidth-1:0] s_awaddr,
  input  logic                 s_awvalid,
  output logic                 s_awready,
  input  logic [DataWidth-1:0] s_wdata,
  input  logic [3:0]           s_wstrb,
  input  logic                 s_wvalid,
  output logic                 s_wready,
  output logic [1:0]           s_bresp,
  output logic                 s_bvalid,
  input  logic                 s_bready,
  input  logic [AddrWidth-1:0] s_araddr,
  input  logic                 s_arvalid,
  output logic                 s_arready,
  output logic [DataWidth-1:0] s_rdata,
  output logic [1:0]           s_rresp,
  output logic                 s_rvalid,
  input  logic                 s_rready,
  output logic                 csr_valid_o,
  output logic                 rd_or_wr_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic [DataWidth-1:0] data_in_o,
  input  logic                 csr_ready_i,
  input  logic                 error_i,
  input  logic [DataWidth-1:0] data_out_i
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  typedef enum logic [2:0] {
    IDLE, WR_REQ, RD_REQ, RD_CAP, B_RESP, R_RESP
`ifdef AXI_CSR_BRIDGE_RMW_EN
    , RMW_RD, RMW_CAP
`endif
  } state_t;

  state_t                state;
  logic                  last_rd;
  logic                  wr_cand;
  logic                  rd_cand;
  logic                  take_rd;
  logic                  take_wr;
  logic [AddrWidth-1:0]  addr_q;
  logic [DataWidth-1:0]  wdata_q;
`ifdef AXI_CSR_BRIDGE_RMW_EN
  logic [3:0]            strb_q;
`endif

  function automatic logic in_window(input logic [AddrWidth-1:0] a);
    logic [AddrWidth-1:0] off;
    off = a - BaseAddr;
    return (a >= BaseAddr) && (off < WindowSize);
  endfunction

`ifdef AXI_CSR_BRIDGE_RMW_EN
  function automatic logic [DataWidth-1:0] merge_bytes(input logic [DataWidth-1:0] wd,
                                                        input logic [DataWidth-1:0] rd,
                                                        input logic [3:0]           strb);
    logic [DataWidth-1:0] res;
    for (int i = 0; i < DataWidth / 8; i++) begin
      res[8*i +: 8] = strb[i] ? wd[8*i +: 8] : rd[8*i +: 8];
    end
    return res;
  endfunction
`endif

  // A write needs AW and W together; on a tie the type not served last wins.
  assign wr_cand   = s_awvalid & s_wvalid;
  assign rd_cand   = s_arvalid;
  assign take_rd   = (state == IDLE) & rd_cand & (~wr_cand | ~last_rd);
  assign take_wr   = (state == IDLE) & wr_cand & (~rd_cand | last_rd);
  assign s_arready = take_rd;
  assign s_awready = take_wr;
  assign s_wready  = take_wr;
  assign addr_o    = addr_q;
  assign data_in_o = wdata_q;

  // Control FSM: arbitration, CSR request sequencing and AXI responses
  always_ff @(posedge clk_axi or posedge arst_axi) begin
    if (arst_axi) begin
      state       <= IDLE;
      last_rd     <= 1'b0;
      csr_valid_o <= 1'b0;
      rd_or_wr_o  <= 1'b0;
      s_bvalid    <= 1'b0;
      s_bresp     <= RespOkay;
      s_rvalid    <= 1'b0;
      s_rresp     <= RespOkay;
      s_rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take_rd) begin
            last_rd <= 1'b1;
            if (in_window(s_araddr)) begin
              state       <= RD_REQ;
              csr_valid_o <= 1'b1;
              rd_or_wr_o  <= 1'b0;
            end else begin
              state    <= R_RESP;
              s_rvalid <= 1'b1;
              s_rresp  <= RespDecErr;
              s_rdata  <= '0;
            end
          end else if (take_wr) begin
            last_rd <= 1'b0;
            if (!in_window(s_awaddr)) begin
              state    <= B_RESP;
              s_bvalid <= 1'b1;
              s_bresp  <= RespDecErr;
            end else if (s_wstrb == 4'hF) begin
              state       <= WR_REQ;
              csr_valid_o <= 1'b1;
              rd_or_wr_o  <= 1'b1;
            end
`ifdef AXI_CSR_BRIDGE_RMW_EN
            else if (s_wstrb == 4'h0) begin
              state    <= B_RESP;
              s_bvalid <= 1'b1;
              s_bresp  <= RespOkay;
            end else begin
              state       <= RMW_RD;
              csr_valid_o <= 1'b1;
              rd_or_wr_o  <= 1'b0;
            end
`else
            else begin
              state    <= B_RESP;
              s_bvalid <= 1'b1;
              s_bresp  <= RespSlvErr;
            end
`endif
          end
        end
        WR_REQ: begin
          if (csr_ready_i) begin
            csr_valid_o <= 1'b0;
            state       <= B_RESP;
            s_bvalid    <= 1'b1;
            s_bresp     <= error_i ? RespSlvErr : RespOkay;
          end
        end
        RD_REQ: begin
          if (csr_ready_i) begin
            csr_valid_o <= 1'b0;
            state       <= RD_CAP;
          end
        end
        RD_CAP: begin
          state    <= R_RESP;
          s_rvalid <= 1'b1;
          s_rresp  <= error_i ? RespSlvErr : RespOkay;
          s_rdata  <= error_i ? '0 : data_out_i;
        end
        B_RESP: begin
          if (s_bready) begin
            s_bvalid <= 1'b0;
            state    <= IDLE;
          end
        end
        R_RESP: begin
          if (s_rready) begin
            s_rvalid <= 1'b0;
            state    <= IDLE;
          end
        end
`ifdef AXI_CSR_BRIDGE_RMW_EN
        RMW_RD: begin
          if (csr_ready_i) begin
            csr_valid_o <= 1'b0;
            state       <= RMW_CAP;
          end
        end
        RMW_CAP: begin
          if (error_i) begin
            state    <= B_RESP;
            s_bvalid <= 1'b1;
            s_bresp  <= RespSlvErr;
          end else begin
            state       <= WR_REQ;
            csr_valid_o <= 1'b1;
            rd_or_wr_o  <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Transaction capture: address, write data and strobes at the AXI handshake
  always_ff @(posedge clk_axi) begin
    if (take_rd) begin
      addr_q <= s_araddr;
    end else if (take_wr) begin
      addr_q  <= s_awaddr;
      wdata_q <= s_wdata;
`ifdef AXI_CSR_BRIDGE_RMW_EN
      strb_q  <= s_wstrb;
`endif
    end
`ifdef AXI_CSR_BRIDGE_RMW_EN
    else if (state == RMW_CAP) begin
      wdata_q <= merge_bytes(wdata_q, data_out_i, strb_q);
    end
`endif
  end

endmodule

// File: tb/tb_axi_csr_bridge.sv
// Self-checking bench for axi_csr_bridge: directed AXI-Lite transactions
// followed by random ones, against a CSR bank responder and a register-level
// reference model of the expected AXI results.
module tb_axi_csr_bridge;

  logic        clk_axi = 1'b0;
  logic        arst_axi;
  logic [31:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic        csr_valid_o;
  logic        rd_or_wr_o;
  logic [31:0] addr_o;
  logic [31:0] data_in_o;
  logic        csr_ready_i;
  logic        error_i;
  logic [31:0] data_out_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // CSR bank responder state
  logic [31:0] csr_mem [32];
  logic [31:0] model_mem [32];
  logic [31:0] last_wr_addr;
  logic [31:0] last_wr_data;
  logic [5:0]  sidx;
  int          acc_cnt = 0;
  int          vld_cnt = 0;
  bit          load_mem;
  bit          hold_rdy;
  bit          rnd_mode;
  logic        rdy_rnd = 1'b1;

  axi_csr_bridge dut (
    .clk_axi(clk_axi), .arst_axi(arst_axi),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .csr_valid_o(csr_valid_o), .rd_or_wr_o(rd_or_wr_o), .addr_o(addr_o), .data_in_o(data_in_o),
    .csr_ready_i(csr_ready_i), .error_i(error_i), .data_out_i(data_out_i)
  );

  always #5 clk_axi = ~clk_axi;

  always @(posedge clk_axi) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input int i);
    if (i == 0) return 32'hCAFE_0001;
    if (i == 8) return 32'h1234_5678;
    return 32'hA500_0000 | 32'(i);
  endfunction

  // CSR bank: word 0 is read-only, offsets 0x80..0xFF are unmapped (error).
  assign sidx        = addr_o[7:2];
  assign data_out_i  = sidx[5] ? 32'hDEAD_BEEF : csr_mem[sidx[4:0]];
  assign error_i     = sidx[5] | (rd_or_wr_o & (sidx == 6'd0));
  assign csr_ready_i = hold_rdy ? 1'b0 : rdy_rnd;

  always @(negedge clk_axi) rdy_rnd <= rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;

  always @(posedge clk_axi) begin
    if (load_mem) begin
      for (int i = 0; i < 32; i++) csr_mem[i] <= init_val(i);
    end else if (csr_valid_o) begin
      vld_cnt <= vld_cnt + 1;
      if (csr_ready_i) begin
        acc_cnt <= acc_cnt + 1;
        if (rd_or_wr_o && !error_i) begin
          csr_mem[sidx[4:0]] <= data_in_o;
          last_wr_addr       <= addr_o;
          last_wr_data       <= data_in_o;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: expected AXI response and number of CSR accesses.
  function automatic void model_read(input logic [31:0] a, output logic [1:0] r,
                                     output logic [31:0] d, output int acc);
    int idx;
    if (a < 32'h1000 || a >= 32'h1100) begin
      r = 2'b11; d = 32'h0; acc = 0;
      return;
    end
    idx = int'((a - 32'h1000) / 4);
    acc = 1;
    if (idx >= 32) begin r = 2'b10; d = 32'h0; end
    else begin r = 2'b00; d = model_mem[idx]; end
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] s, output logic [1:0] r, output int acc);
    int idx;
    logic [31:0] nd;
    if (a < 32'h1000 || a >= 32'h1100) begin
      r = 2'b11; acc = 0;
      return;
    end
    idx = int'((a - 32'h1000) / 4);
    nd  = d;
    if (s != 4'hF) begin
`ifdef AXI_CSR_BRIDGE_RMW_EN
      if (s == 4'h0) begin r = 2'b00; acc = 0; return; end
      if (idx >= 32) begin r = 2'b10; acc = 1; return; end
      nd = model_mem[idx];
      for (int b = 0; b < 4; b++) begin
        logic [31:0] m;
        m  = s[b] ? (32'hFF << (8 * b)) : 32'h0;
        nd = (nd & ~m) | (d & m);
      end
      acc = 2;
      if (idx == 0) r = 2'b10;
      else begin model_mem[idx] = nd; r = 2'b00; end
      return;
`else
      r = 2'b10; acc = 0;
      return;
`endif
    end
    acc = 1;
    if (idx == 0 || idx >= 32) r = 2'b10;
    else begin model_mem[idx] = nd; r = 2'b00; end
  endfunction

  task automatic check_access(input string tag, input int ea, input int a0, input int v0);
    if (ea == 0) check({tag, "_no_csr_valid"}, vld_cnt - v0, 0);
    else check({tag, "_csr_accesses"}, acc_cnt - a0, ea);
  endtask

  task automatic wait_hs(input bit is_rd, output int c0, output bit ok);
    int t = 0;
    forever begin
      #1;
      if ((is_rd ? s_arready : s_awready) || t >= 100) break;
      @(negedge clk_axi);
      t++;
    end
    ok = is_rd ? s_arready : s_awready;
    check(is_rd ? "ar_handshake" : "aw_handshake", 32'(ok), 1);
    if (!is_rd && ok) check("wready_with_awready", 32'(s_wready), 1);
    c0 = cyc;
  endtask

  task automatic finish_read(input logic [1:0] er, input logic [31:0] ed, input int ea,
                             input int a0, input int v0, input int c0, input int lat, input int stall);
    int t = 0;
    logic [31:0] d0;
    forever begin
      #1;
      if (s_rvalid || t >= 100) break;
      @(negedge clk_axi);
      t++;
    end
    check("rvalid_arrives", 32'(s_rvalid), 1);
    if (!s_rvalid) return;
    if (lat >= 0) check("r_latency", cyc - c0, lat);
    check("rresp", 32'(s_rresp), 32'(er));
    check("rdata", s_rdata, ed);
    d0 = s_rdata;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk_axi);
      s_araddr = 32'h1004; s_arvalid = 1'b1;
      #1;
      check("stall_rvalid", 32'(s_rvalid), 1);
      check("stall_rdata", s_rdata, d0);
      check("stall_arready", 32'(s_arready), 0);
    end
    @(negedge clk_axi);
    s_arvalid = 1'b0; s_rready = 1'b1;
    @(negedge clk_axi);
    s_rready = 1'b0;
    #1;
    check("rvalid_clears", 32'(s_rvalid), 0);
    check_access("rd", ea, a0, v0);
  endtask

  task automatic finish_write(input logic [1:0] er, input int ea, input int a0, input int v0,
                              input int c0, input int lat, input int stall);
    int t = 0;
    logic [1:0] r0;
    forever begin
      #1;
      if (s_bvalid || t >= 100) break;
      @(negedge clk_axi);
      t++;
    end
    check("bvalid_arrives", 32'(s_bvalid), 1);
    if (!s_bvalid) return;
    if (lat >= 0) check("b_latency", cyc - c0, lat);
    check("bresp", 32'(s_bresp), 32'(er));
    r0 = s_bresp;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk_axi);
      s_awaddr = 32'h1014; s_awvalid = 1'b1; s_wvalid = 1'b1;
      #1;
      check("stall_bvalid", 32'(s_bvalid), 1);
      check("stall_bresp", 32'(s_bresp), 32'(r0));
      check("stall_awready", 32'(s_awready), 0);
    end
    @(negedge clk_axi);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
    @(negedge clk_axi);
    s_bready = 1'b0;
    #1;
    check("bvalid_clears", 32'(s_bvalid), 0);
    check_access("wr", ea, a0, v0);
  endtask

  task automatic do_read(input logic [31:0] a, input int stall);
    logic [1:0] er; logic [31:0] ed; int ea, a0, v0, c0; bit ok;
    @(negedge clk_axi);
    a0 = acc_cnt; v0 = vld_cnt;
    s_araddr = a; s_arvalid = 1'b1;
    wait_hs(1'b1, c0, ok);
    @(negedge clk_axi);
    s_arvalid = 1'b0;
    if (!ok) return;
    model_read(a, er, ed, ea);
    finish_read(er, ed, ea, a0, v0, c0, (ea == 1 && !rnd_mode) ? 3 : -1, stall);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int stall);
    logic [1:0] er; int ea, a0, v0, c0; bit ok;
    @(negedge clk_axi);
    a0 = acc_cnt; v0 = vld_cnt;
    s_awaddr = a; s_wdata = d; s_wstrb = s; s_awvalid = 1'b1; s_wvalid = 1'b1;
    wait_hs(1'b0, c0, ok);
    @(negedge clk_axi);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    if (!ok) return;
    model_write(a, d, s, er, ea);
    finish_write(er, ea, a0, v0, c0, (ea == 1 && s == 4'hF && !rnd_mode) ? 2 : -1, stall);
  endtask

  // Read and write presented in the same cycle: read is expected to win here.
  task automatic do_tie(input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] wd);
    logic [1:0] er; logic [31:0] ed; int ea, a0, v0, c0; bit ok;
    @(negedge clk_axi);
    a0 = acc_cnt; v0 = vld_cnt;
    s_araddr = ra; s_arvalid = 1'b1;
    s_awaddr = wa; s_wdata = wd; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
    #1;
    check("tie_arready", 32'(s_arready), 1);
    check("tie_awready", 32'(s_awready), 0);
    c0 = cyc;
    @(negedge clk_axi);
    s_arvalid = 1'b0;
    model_read(ra, er, ed, ea);
    finish_read(er, ed, ea, a0, v0, c0, 3, 0);
    a0 = acc_cnt; v0 = vld_cnt;
    wait_hs(1'b0, c0, ok);
    @(negedge clk_axi);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    if (!ok) return;
    model_write(wa, wd, 4'hF, er, ea);
    finish_write(er, ea, a0, v0, c0, 2, 0);
    check("tie_csr_wr_addr", last_wr_addr, wa);
    check("tie_csr_wr_data", last_wr_data, wd);
  endtask

  initial begin
    logic [31:0] a;
    int          c0;
    bit          ok;
    arst_axi = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    hold_rdy = 1'b0; rnd_mode = 1'b0; load_mem = 1'b1;
    for (int i = 0; i < 32; i++) model_mem[i] = init_val(i);
    repeat (3) @(negedge clk_axi);
    #1;
    check("rst_arready", 32'(s_arready), 0);
    check("rst_awready", 32'(s_awready), 0);
    check("rst_wready", 32'(s_wready), 0);
    check("rst_bvalid", 32'(s_bvalid), 0);
    check("rst_rvalid", 32'(s_rvalid), 0);
    check("rst_csr_valid", 32'(csr_valid_o), 0);
    check("rst_bresp", 32'(s_bresp), 0);
    check("rst_rresp", 32'(s_rresp), 0);
    check("rst_rdata", s_rdata, 0);
    @(negedge clk_axi);
    arst_axi = 1'b0; load_mem = 1'b0;

    // Read 0x1000 wins the first tie, then write 0x1010 <- 3; next tie read again.
    do_tie(32'h1000, 32'h1010, 32'h0000_0003);
    do_tie(32'h1004, 32'h1014, 32'h0BAD_F00D);

    // Error mapping: read-only register, unmapped offset, outside the window.
    do_write(32'h1000, 32'h1111_1111, 4'hF, 0);
    do_read(32'h1080, 0);
    do_read(32'h2000, 0);
    do_write(32'h0FFC, 32'h2222_2222, 4'hF, 0);

    // Partial strobe on the 0x1234_5678 register at 0x1020.
    do_write(32'h1020, 32'h0000_00AB, 4'h1, 0);
`ifdef AXI_CSR_BRIDGE_RMW_EN
    check("partial_strobe_reg", csr_mem[8], 32'h1234_56AB);
`else
    check("partial_strobe_reg", csr_mem[8], 32'h1234_5678);
`endif
    do_read(32'h1020, 0);

    // Response back-pressure.
    do_read(32'h1004, 5);
    do_write(32'h1018, 32'h7777_0000, 4'hF, 3);

    // Reset while a write waits in the CSR request phase.
    hold_rdy = 1'b1;
    @(negedge clk_axi);
    s_awaddr = 32'h1030; s_wdata = 32'h5555_AAAA; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    wait_hs(1'b0, c0, ok);
    @(negedge clk_axi);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    #1;
    check("midrst_csr_valid", 32'(csr_valid_o), 1);
    check("midrst_rd_or_wr", 32'(rd_or_wr_o), 1);
    repeat (2) @(negedge clk_axi);
    arst_axi = 1'b1;
    #1;
    check("midrst_csr_valid_drop", 32'(csr_valid_o), 0);
    repeat (2) @(negedge clk_axi);
    arst_axi = 1'b0; hold_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_axi);
      #1;
      check("midrst_no_bvalid", 32'(s_bvalid), 0);
    end
    do_tie(32'h1008, 32'h101C, 32'h0000_0099);

    // Random traffic with a randomly stalling CSR bank.
    rnd_mode = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 8) a = 32'h1000 + ($urandom_range(0, 63) << 2);
      else if (sel == 8) a = 32'h2000 + ($urandom_range(0, 63) << 2);
      else a = 32'h0FFC;
      if ($urandom_range(0, 1) == 1) begin
        do_read(a, int'($urandom_range(0, 3)));
      end else begin
        logic [3:0] s;
        s = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
        do_write(a, $urandom, s, int'($urandom_range(0, 3)));
      end
    end
    rnd_mode = 1'b0;

    @(negedge clk_axi);
    for (int i = 0; i < 32; i++) check("final_reg", csr_mem[i], model_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
